// File: rtl/power_mgr_pkg.sv
// Shared definitions for the power-mode controller.
// Contents:
//   pm_state_e  - 2-bit controller state: SLEEP=0, WAKE=1, NORMAL=2, LOWPWR=3
//   cnt_width() - counter width needed to hold the values 0..n-1 (at least 1 bit)
package power_mgr_pkg;

    typedef enum logic [1:0] {
        ST_SLEEP  = 2'd0,
        ST_WAKE   = 2'd1,
        ST_NORMAL = 2'd2,
        ST_LOWPWR = 2'd3
    } pm_state_e;

    // Width of a counter that runs 0..n-1. $clog2 returns 0 for n<=1,
    // so the result is clamped to one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : power_mgr_pkg

// File: rtl/dwell_counter.sv
// Dwell counter: counts cycles while inc is high and flags the last cycle
// of a dwell of CYCLES cycles. The count holds at CYCLES-1 rather than wrapping.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (count -> 0)
//   clear  in   force count to 0 (wins over inc)
//   inc    in   advance count by one
//   tc     out  count == CYCLES-1 (terminal cycle of the dwell)
module dwell_counter
    import power_mgr_pkg::*;
#(
    parameter int CYCLES = 16,
    parameter int WIDTH  = cnt_width(CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear dominates, saturate on the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != LAST)) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == LAST);

endmodule : dwell_counter

// File: rtl/power_mode_ctrl.sv
// Power-mode controller: gates NUM_CH peripheral enables from per-channel
// requests and selects fast/slow clock, with a wake settle dwell, a
// low-power channel mask, an always-on override and ADC gating.
// Optional feature macro: POWER_HYST_EN (low_power release hysteresis of
// HYST_CYCLES consecutive low_power=0 cycles before LOWPWR -> NORMAL).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   solar_on     harvest supply good (0 forces SLEEP)
//   always_on    OR ALWAYS_ON_MASK into the enables
//   low_power    request LOWPWR
//   adc_enable   permit channel ADC_CH (not overridden by always_on)
//   ch_request   per-channel enable requests
//   enable       registered channel enables
//   clockspeed   1 = fast clock (NORMAL only)
//   state        current state encoding
//   mode_change  one-cycle pulse when the state changes
module power_mode_ctrl
    import power_mgr_pkg::*;
#(
    parameter int                NUM_CH         = 8,
    parameter logic [NUM_CH-1:0] ALWAYS_ON_MASK = 8'h01,
    parameter logic [NUM_CH-1:0] LP_MASK        = 8'h0F,
    parameter int                ADC_CH         = 7,
    parameter int                SETTLE_CYCLES  = 16,
    parameter int                HYST_CYCLES    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              solar_on,
    input  logic              always_on,
    input  logic              low_power,
    input  logic              adc_enable,
    input  logic [NUM_CH-1:0] ch_request,
    output logic [NUM_CH-1:0] enable,
    output logic              clockspeed,
    output logic [1:0]        state,
    output logic              mode_change
);

    pm_state_e         state_q, state_d;
    pm_state_e         mode_next_s;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [NUM_CH-1:0] base_en_s;
    logic              clockspeed_q, clockspeed_d;
    logic              mode_change_q, mode_change_d;
    logic              settle_tc_s;
    logic              release_ok_s;

    // Settle counter is held at 0 outside WAKE, so it starts from 0 on entry.
    dwell_counter #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != ST_WAKE),
        .inc   (state_q == ST_WAKE),
        .tc    (settle_tc_s)
    );

`ifdef POWER_HYST_EN
    logic hyst_tc_s;

    // Counts consecutive low_power=0 cycles in LOWPWR; any request restarts it.
    dwell_counter #(
        .CYCLES (HYST_CYCLES)
    ) u_hyst (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q != ST_LOWPWR) || low_power),
        .inc   ((state_q == ST_LOWPWR) && !low_power),
        .tc    (hyst_tc_s)
    );

    assign release_ok_s = hyst_tc_s && !low_power;
`else
    // HYST_CYCLES is only meaningful with hysteresis; the term folds to 1.
    assign release_ok_s = !low_power && (HYST_CYCLES >= 1);
`endif

    // Mode transitions ignoring supply loss.
    always_comb begin
        mode_next_s = state_q;
        case (state_q)
            ST_SLEEP: begin
                if (solar_on) mode_next_s = ST_WAKE;
                else          mode_next_s = ST_SLEEP;
            end
            ST_WAKE: begin
                if (settle_tc_s) mode_next_s = low_power ? ST_LOWPWR : ST_NORMAL;
                else             mode_next_s = ST_WAKE;
            end
            ST_NORMAL: begin
                if (low_power) mode_next_s = ST_LOWPWR;
                else           mode_next_s = ST_NORMAL;
            end
            ST_LOWPWR: begin
                if (release_ok_s) mode_next_s = ST_NORMAL;
                else              mode_next_s = ST_LOWPWR;
            end
            default: mode_next_s = ST_SLEEP;
        endcase
    end

    // Supply loss overrides every other transition; outputs follow next state.
    always_comb begin
        state_d = solar_on ? mode_next_s : ST_SLEEP;

        base_en_s = '0;
        case (state_d)
            ST_NORMAL: base_en_s = ch_request;
            ST_LOWPWR: base_en_s = ch_request & LP_MASK;
            default:   base_en_s = '0;
        endcase

        enable_d = base_en_s;
        if (always_on) begin
            enable_d = base_en_s | ALWAYS_ON_MASK;
        end else begin
            enable_d = base_en_s;
        end
        // ADC gating is applied last so always_on cannot power the ADC.
        enable_d[ADC_CH] = enable_d[ADC_CH] & adc_enable;

        clockspeed_d  = (state_d == ST_NORMAL);
        mode_change_d = (state_d != state_q);
    end

    // State and output registers, updated on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SLEEP;
            enable_q      <= '0;
            clockspeed_q  <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            clockspeed_q  <= clockspeed_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign enable      = enable_q;
    assign clockspeed  = clockspeed_q;
    assign state       = state_q;
    assign mode_change = mode_change_q;

endmodule : power_mode_ctrl

// File: tb/tb_power_mode_ctrl.sv
// Scoreboard bench for power_mode_ctrl (NUM_CH=8, SETTLE=4, HYST=3).
// Stimulus is applied on the falling edge; the reference model predicts the
// outputs after the next rising edge and queues them; a monitor pops and
// compares one entry after each rising edge.
module tb_power_mode_ctrl;

    localparam int SETTLE = 4;
    localparam int HYST   = 3;
    localparam logic [7:0] AOM  = 8'h01;
    localparam logic [7:0] LPM  = 8'h0F;
    localparam int ADC_IDX      = 7;

    localparam int M_SLEEP  = 0;
    localparam int M_WAKE   = 1;
    localparam int M_NORMAL = 2;
    localparam int M_LOWPWR = 3;

    typedef struct packed {
        logic [7:0] en;
        logic       cs;
        logic [1:0] st;
        logic       mc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       solar_on = 1'b0;
    logic       always_on = 1'b0;
    logic       low_power = 1'b0;
    logic       adc_enable = 1'b0;
    logic [7:0] ch_request = 8'h00;
    logic [7:0] enable;
    logic       clockspeed;
    logic [1:0] state;
    logic       mode_change;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 1'b0;

    // Reference model state: current mode, WAKE cycles already spent,
    // consecutive low_power=0 cycles seen while in LOWPWR.
    int m_mode     = M_SLEEP;
    int m_wake_cnt = 0;
    int m_rel_run  = 0;

    power_mode_ctrl #(
        .NUM_CH         (8),
        .ALWAYS_ON_MASK (AOM),
        .LP_MASK        (LPM),
        .ADC_CH         (ADC_IDX),
        .SETTLE_CYCLES  (SETTLE),
        .HYST_CYCLES    (HYST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .solar_on    (solar_on),
        .always_on   (always_on),
        .low_power   (low_power),
        .adc_enable  (adc_enable),
        .ch_request  (ch_request),
        .enable      (enable),
        .clockspeed  (clockspeed),
        .state       (state),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    // Predict the outputs produced by the coming rising edge.
    task automatic model_step();
        int   nxt;
        int   run;
        exp_t e;
        run = 0;
        if (reset) begin
            m_mode = M_SLEEP; m_wake_cnt = 0; m_rel_run = 0;
            e.en = 8'h00; e.cs = 1'b0; e.st = 2'd0; e.mc = 1'b0;
            exp_q.push_back(e);
            return;
        end
        nxt = m_mode;
        if (m_mode == M_SLEEP) begin
            if (solar_on) nxt = M_WAKE;
        end else if (m_mode == M_WAKE) begin
            // this cycle is WAKE cycle number m_wake_cnt+1
            if (m_wake_cnt + 1 >= SETTLE) nxt = low_power ? M_LOWPWR : M_NORMAL;
        end else if (m_mode == M_NORMAL) begin
            if (low_power) nxt = M_LOWPWR;
        end else begin
            run = low_power ? 0 : m_rel_run + 1;
`ifdef POWER_HYST_EN
            if (run >= HYST) nxt = M_NORMAL;
`else
            if (!low_power) nxt = M_NORMAL;
`endif
        end
        if (!solar_on) nxt = M_SLEEP;

        m_wake_cnt = (nxt == M_WAKE && m_mode == M_WAKE) ? m_wake_cnt + 1 : 0;
        m_rel_run  = (nxt == M_LOWPWR && m_mode == M_LOWPWR) ? run : 0;

        if (nxt == M_NORMAL)      e.en = ch_request;
        else if (nxt == M_LOWPWR) e.en = ch_request & LPM;
        else                      e.en = 8'h00;
        if (always_on) e.en = e.en | AOM;
        if (!adc_enable) e.en[ADC_IDX] = 1'b0;
        e.cs = (nxt == M_NORMAL);
        e.st = 2'(nxt);
        e.mc = (nxt != m_mode);
        m_mode = nxt;
        exp_q.push_back(e);
    endtask

    // One stimulus cycle: drive on the falling edge, then queue the prediction.
    task automatic cyc(input logic r, input logic s, input logic ao, input logic lp,
                       input logic adc, input logic [7:0] req, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset = r; solar_on = s; always_on = ao; low_power = lp;
            adc_enable = adc; ch_request = req;
            model_step();
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (enable === e.en && clockspeed === e.cs && state === e.st &&
                    mode_change === e.mc) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs check %0d @%0t: got en=%h cs=%b st=%0d mc=%b, want en=%h cs=%b st=%0d mc=%b",
                             n_checks, $time, enable, clockspeed, state, mode_change,
                             e.en, e.cs, e.st, e.mc);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic r, s, ao, lp, adc;
        // 1: reset with every input high
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 3);
        // 2: wake settle then NORMAL
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 6);
        // 3: ADC gating, then LOWPWR
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 2);
        // 4: always_on, supply loss into SLEEP, ADC gating beats always_on
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 2);
        // 5: back to LOWPWR, interrupted release, then full release
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 6);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4);
        // 6: reset mid-WAKE, full settle afterwards, supply loss on terminal cycle
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 2);
        // Random traffic: supply mostly good, low_power toggles in runs
        lp = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 19) != 0);
            ao  = $urandom_range(0, 1) != 0;
            adc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) lp = ~lp;
            cyc(r, s, ao, lp, adc, 8'($urandom), 1);
        end
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_power_mode_ctrl
